// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: IF/ID-class pipeline register with valid/ready, hazard stall and flush.
// Define PIPE_STAGE_SKID_EN to add the skid entry (level up to 2, in_ready free of out_ready).
module pipe_stage_skid #(
  parameter int unsigned     IR_W   = 32,
  parameter int unsigned     PC_W   = 32,
  parameter logic [IR_W-1:0] NOP_IR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IR_W-1:0] ir_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IR_W-1:0] ir_out,
  output logic [PC_W-1:0] pc_out,
  output logic [1:0]      level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [IR_W-1:0] m_ir_q, m_ir_d;
  logic [PC_W-1:0] m_pc_q, m_pc_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [IR_W-1:0] s_ir_q, s_ir_d;
  logic [PC_W-1:0] s_pc_q, s_pc_d;
`endif

  logic acc;
  logic pop;

`ifdef PIPE_STAGE_SKID_EN
  // Ready depends only on held state, stall and flush: no path from out_ready.
  assign in_ready = ~flush & ~stall & (state_q != ST_FULL);
`else
  assign in_ready = ~flush & ~stall & (~out_valid_q | out_ready);
`endif

  assign acc = in_valid & in_ready;
  assign pop = out_valid_q & out_ready & ~stall;

  // Main entry is reloaded with the bubble whenever the stage empties.
  assign out_valid = out_valid_q;
  assign ir_out    = m_ir_q;
  assign pc_out    = m_pc_q;
  assign level     = 2'(state_q);

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    m_ir_d  = m_ir_q;
    m_pc_d  = m_pc_q;
`ifdef PIPE_STAGE_SKID_EN
    s_ir_d  = s_ir_q;
    s_pc_d  = s_pc_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
      m_ir_d  = NOP_IR;
      m_pc_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_HALF;
            m_ir_d  = ir_in;
            m_pc_d  = pc_in;
          end
        end
        ST_HALF: begin
          if (acc && pop) begin
            m_ir_d = ir_in;
            m_pc_d = pc_in;
`ifdef PIPE_STAGE_SKID_EN
          end else if (acc) begin
            state_d = ST_FULL;
            s_ir_d  = ir_in;
            s_pc_d  = pc_in;
`endif
          end else if (pop) begin
            state_d = ST_EMPTY;
            m_ir_d  = NOP_IR;
            m_pc_d  = '0;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (pop) begin
            state_d = ST_HALF;
            m_ir_d  = s_ir_q;
            m_pc_d  = s_pc_q;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          m_ir_d  = NOP_IR;
          m_pc_d  = '0;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      m_ir_q      <= NOP_IR;
      m_pc_q      <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_ir_q      <= '0;
      s_pc_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      m_ir_q      <= m_ir_d;
      m_pc_q      <= m_pc_d;
`ifdef PIPE_STAGE_SKID_EN
      s_ir_q      <= s_ir_d;
      s_pc_q      <= s_pc_d;
`endif
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised IF/ID-class pipeline stage register with a valid/ready handshake, hazard stall, branch flush and an optional two-entry skid buffer. It sits between any two CPU pipeline stages (IF→ID first) and carries an instruction word plus its PC. It replaces plain enable-gated IR/PC registers with a stage that can absorb one in-flight word when downstream stalls, and that inserts a NOP bubble on flush.

## Interface
Parameters:
- IR_W, 32, instruction word width
- PC_W, 32, PC width
- NOP_IR, 32'h0000_0000, IR value driven while the stage is empty (bubble)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hazard stall: no accept, no pop, contents held
- flush  in  1  discard all contents; priority over everything except rst
- in_valid  in  1  upstream word present
- in_ready  out  1  stage can accept this cycle
- ir_in  in  IR_W  incoming instruction
- pc_in  in  PC_W  incoming PC
- out_valid  out  1  ir_out/pc_out hold a real instruction
- out_ready  in  1  downstream consumes this cycle
- ir_out  out  IR_W  instruction to next stage (NOP_IR when empty)
- pc_out  out  PC_W  PC to next stage (0 when empty)
- level  out  2  occupancy: 0, 1 or 2

## Operation
- Storage: main entry M (drives outputs) and skid entry S (skid build only).
- acc = in_valid & in_ready; pop = out_valid & out_ready & ~stall.
- in_ready = ~flush & ~stall & ~S_valid (skid build).
- States: EMPTY (level 0), HALF (level 1, M valid), FULL (level 2, M and S valid).
- EMPTY: acc → HALF, M←in. Otherwise stay.
- HALF: acc&pop → HALF, M←in. acc&~pop → FULL, S←in. ~acc&pop → EMPTY. Neither → hold.
- FULL: in_ready=0. pop → HALF, M←S, S invalidated. Otherwise hold.
- flush=1 → next state EMPTY regardless of state/in_valid/stall; nothing accepted in that cycle.
- stall=1 without flush → every register holds; out_valid stays as is; ir_out/pc_out stable.
- Order preserved: data leaves in acceptance order; S never bypasses M.
- Outputs when out_valid=0: ir_out=NOP_IR, pc_out=0 (forced, not stale data).

## Timing
- Reset (rst=0, async): state EMPTY, level=0, out_valid=0, ir_out=NOP_IR, pc_out=0; in_ready reflects ~flush&~stall once S_valid is cleared. Mid-operation reset discards both entries immediately.
- Latency: accept at edge N → out_valid=1 with that word after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle with out_ready held high.
- Skid build: in_ready is registered-state + stall/flush only; it has no combinational path from out_ready.
- Simultaneous flush and acc-eligible in_valid: word dropped, upstream sees in_ready=0.
- Simultaneous stall and out_ready=1: no pop.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer as above; level reaches 2.
- Undefined: S removed; FULL unreachable; level ≤ 1; in_ready = ~flush & ~stall & (~out_valid | out_ready) (combinational from out_ready); all other behaviour identical.

## Test plan
- Reset: rst=0 with in_valid=1, ir_in=32'hDEAD_BEEF → out_valid=0, ir_out=32'h0, pc_out=0, level=0; after rst release, first accept appears 1 cycle later.
- Streaming: out_ready=1, push PC 0x00,0x04,0x08 with IR 0x11,0x22,0x33 back-to-back → same sequence on outputs, one per cycle, 1-cycle latency, level=1 throughout.
- Backpressure (skid): HALF holding 0x11, out_ready=0, push 0x22 → level=2, in_ready=0; out_ready=1 → 0x11 then 0x22 popped in order, level 2→1→0.
- Flush: FULL with 0x11/0x22, flush=1 with in_valid=1 ir_in=0x33 → next cycle level=0, out_valid=0, ir_out=NOP_IR; 0x33 never appears.
- Stall: HALF with IR 0x44 PC 0x10, stall=1 for 3 cycles with out_ready=1 and in_valid=1 → outputs hold 0x44/0x10, in_ready=0, no pop; release → 0x44 consumed.
- No-skid build: out_valid=1, out_ready=0 → in_ready=0 same cycle; out_ready=1 → in_ready=1 same cycle, level never exceeds 1.
